// File: rtl/memory_access_stage_if.sv
// Bus bundles around the MEM stage: execute->mem issue, mem->dcache request,
// and the mem->writeback beat.

interface ex_mem_if;
  logic        mem_enable;
  logic [63:0] alu_result;
  logic [63:0] store_data;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        mem_busy;

  modport master (
    output mem_enable, alu_result, store_data, is_load, is_store, funct3, rd,
    input  mem_busy
  );
  modport slave (
    input  mem_enable, alu_result, store_data, is_load, is_store, funct3, rd,
    output mem_busy
  );
endinterface

interface dcache_if;
  logic        dcache_req;
  logic        dcache_we;
  logic [63:0] dcache_addr;
  logic [63:0] dcache_wdata;
  logic [7:0]  dcache_wstrb;
  logic [63:0] dcache_rdata;
  logic        dcache_ack;

  modport master (
    output dcache_req, dcache_we, dcache_addr, dcache_wdata, dcache_wstrb,
    input  dcache_rdata, dcache_ack
  );
  modport slave (
    input  dcache_req, dcache_we, dcache_addr, dcache_wdata, dcache_wstrb,
    output dcache_rdata, dcache_ack
  );
endinterface

interface mem_wb_if;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        mem_fault;

  modport master (output wb_valid, wb_data, wb_rd, mem_fault);
  modport slave  (input  wb_valid, wb_data, wb_rd, mem_fault);
endinterface

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: one dcache transaction per load/store with lane alignment,
// sign/zero extension and strobe generation; non-memory results pass through.

module memory_access_stage (
  input  logic     clk,
  input  logic     reset,
  ex_mem_if.slave  ex_i,
  dcache_if.master dc_o,
  mem_wb_if.master wb_o
);

  localparam int XLEN  = 64;
  localparam int BYTES = XLEN / 8;

  // state   | meaning
  // IDLE    | waiting for mem_enable; captures the instruction
  // REQ     | dcache_req held until dcache_ack
  // RESP    | one-cycle writeback beat
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              load_q, load_d;
  logic              store_q, store_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              fault_q, fault_d;

  logic              mem_op_in;
  logic              misaligned_in;
  logic              fault_in;
  logic [2:0]        off_in;

  logic [2:0]        off_q;
  logic [5:0]        shamt;
  logic [BYTES-1:0]  strb_base;
  logic [BYTES-1:0]  store_strb;
  logic [XLEN-1:0]   store_lanes;
  logic [XLEN-1:0]   lane;
  logic [XLEN-1:0]   load_val;

  always_comb begin
    off_in    = ex_i.alu_result[2:0];
    mem_op_in = ex_i.is_load | ex_i.is_store;
    case (ex_i.funct3[1:0])
      2'b00:   misaligned_in = 1'b0;
      2'b01:   misaligned_in = off_in[0];
      2'b10:   misaligned_in = |off_in[1:0];
      default: misaligned_in = |off_in;
    endcase
    fault_in = mem_op_in & ((ex_i.funct3 == 3'b111) | misaligned_in);
  end

  always_comb begin
    off_q = addr_q[2:0];
    shamt = {off_q, 3'b000};
    case (f3_q[1:0])
      2'b00:   strb_base = 8'h01;
      2'b01:   strb_base = 8'h03;
      2'b10:   strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
    store_strb  = strb_base << off_q;
    store_lanes = sdata_q << shamt;
  end

  always_comb begin
    lane = rdata_q >> shamt;
    case (f3_q)
      3'b000:  load_val = {{56{lane[7]}},  lane[7:0]};
      3'b001:  load_val = {{48{lane[15]}}, lane[15:0]};
      3'b010:  load_val = {{32{lane[31]}}, lane[31:0]};
      3'b100:  load_val = {56'd0, lane[7:0]};
      3'b101:  load_val = {48'd0, lane[15:0]};
      3'b110:  load_val = {32'd0, lane[31:0]};
      default: load_val = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    rdata_d = rdata_q;
    load_d  = load_q;
    store_d = store_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    fault_d = fault_q;

    dc_o.dcache_req   = 1'b0;
    dc_o.dcache_we    = 1'b0;
    dc_o.dcache_addr  = '0;
    dc_o.dcache_wdata = '0;
    dc_o.dcache_wstrb = '0;
    wb_o.wb_valid     = 1'b0;
    wb_o.wb_data      = '0;
    wb_o.wb_rd        = '0;
    wb_o.mem_fault    = 1'b0;
    ex_i.mem_busy     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_i.mem_enable) begin
          addr_d  = ex_i.alu_result;
          sdata_d = ex_i.store_data;
          load_d  = ex_i.is_load;
          store_d = ex_i.is_store;
          f3_d    = ex_i.funct3;
          rd_d    = ex_i.rd;
          fault_d = fault_in;
          rdata_d = '0;
          state_d = (mem_op_in && !fault_in) ? ST_REQ : ST_RESP;
        end
      end
      ST_REQ: begin
        ex_i.mem_busy    = 1'b1;
        dc_o.dcache_req  = 1'b1;
        dc_o.dcache_we   = store_q;
        dc_o.dcache_addr = {addr_q[XLEN-1:3], 3'b000};
        if (store_q) begin
          dc_o.dcache_wdata = store_lanes;
          dc_o.dcache_wstrb = store_strb;
        end
        if (dc_o.dcache_ack) begin
          rdata_d = dc_o.dcache_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        ex_i.mem_busy  = 1'b1;
        wb_o.wb_valid  = 1'b1;
        wb_o.mem_fault = fault_q;
        // stores and faults retire with no register write
        if (!fault_q && !store_q) begin
          wb_o.wb_rd   = rd_q;
          wb_o.wb_data = load_q ? load_val : addr_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      sdata_q <= '0;
      rdata_q <= '0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      f3_q    <= '0;
      rd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      rdata_q <= rdata_d;
      load_q  <= load_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      fault_q <= fault_d;
    end
  end

endmodule
